fetch_stage: RTL

Instruction-fetch stage and load-use hazard unit for the 5-stage 8-bit CPU. Holds the PC, drives the instruction-memory address, and loads the IF/ID pipeline register. It consumes the branch redirect (`pc_src`, `if_flush`, `branch_target`) produced by the ID-stage control decoder. It produces the `ctrl_mux` bubble request that forces that decoder's outputs to zero.

---
 rtl/fetch_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and load-use hazard unit for the
// 5-stage 8-bit CPU.
//
// What this block does:
// - Holds the PC, which also serves as the instruction-memory address.
// - Loads the IF/ID pipeline register.
// - Applies branch redirects coming from the ID-stage decoder.
// - Raises ctrl_mux to bubble the decoder on a load-use hazard.
//
// Optional feature: define FETCH_PERF_EN to add the saturating 16-bit
// stall_count and flush_count performance counters.
module fetch_stage #(
    parameter int                 INSTR_W  = 16,
    parameter int                 PC_W     = 8,
    parameter logic [INSTR_W-1:0] NOP_WORD = 16'hF000
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               pc_src,
    input  logic               if_flush,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               idex_memread,
    input  logic [2:0]         idex_rt,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic               ctrl_mux
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        stall_count,
    output logic [15:0]        flush_count
`endif
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic [PC_W-1:0]    pc_plus1;
    logic               stall;
    logic               redirect;

    // Load-use hazard: a load in ID/EX writes a source register of the
    // instruction in IF/ID. A NOP bubble never counts as a consumer.
    always_comb begin
        ctrl_mux = idex_memread && (ifid_instr_q != NOP_WORD) &&
                   ((idex_rt == ifid_instr_q[11:9]) ||
                    (idex_rt == ifid_instr_q[8:6]));
        stall    = ctrl_mux;
        redirect = pc_src || if_flush;
        pc_plus1 = pc_q + PC_W'(1);
    end

    // Next PC / IF/ID: a redirect beats a stall, and a stall beats a
    // normal fetch. pc_src and if_flush are each honoured on their own.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (redirect) begin
            pc_d = pc_src ? branch_target : pc_plus1;
            if (if_flush) begin
                ifid_instr_d = NOP_WORD;
                ifid_pc_d    = '0;
            end else begin
                ifid_instr_d = imem_data;
                ifid_pc_d    = pc_plus1;
            end
        end else if (!stall) begin
            pc_d         = pc_plus1;
            ifid_instr_d = imem_data;
            ifid_pc_d    = pc_plus1;
        end
    end

    // PC and IF/ID registers; reset discards any pending stall or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            ifid_instr_q <= NOP_WORD;
            ifid_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;

`ifdef FETCH_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    // Saturating counters. A stall overridden by a redirect is not counted
    // as a stall.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && !redirect && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        if (if_flush && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
